// File: rtl/sobel_conv_engine.sv
// Sobel edge engine: latches an NxN frame on start, sweeps a 3x3 window in raster
// order one pixel per clock, and writes |Gx|, |Gy|, |Gx|+|Gy| or a thresholded edge map.
module sobel_conv_engine #(
  parameter int unsigned N  = 9,
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DW-1:0]     threshold,
  input  logic [N*N*DW-1:0] input_matrix,
  output logic [N*N*DW-1:0] output_matrix,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NN = N * N;
  localparam int unsigned IW = $clog2(NN);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned SW = DW + 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   pix_q [NN];
  logic [DW-1:0]   pix_d [NN];
  logic [DW-1:0]   out_q [NN];
  logic [DW-1:0]   out_d [NN];
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   thr_q, thr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;

  logic            interior;
  logic [IW-1:0]   a_ul, a_u, a_ur, a_l, a_r, a_dl, a_d, a_dr;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]   abs_gx, abs_gy, mag;
  logic [DW-1:0]   result;

  function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] p);
    return signed'({4'b0000, p});
  endfunction

  function automatic logic [DW-1:0] sat(input logic [SW-1:0] v);
    return (|v[SW-1:DW]) ? '1 : v[DW-1:0];
  endfunction

  // Neighbour addresses are only formed for interior pixels so every read stays in range.
  always_comb begin
    interior = (row_q != '0) && (row_q != CW'(N - 1)) &&
               (col_q != '0) && (col_q != CW'(N - 1));
    a_u  = '0;
    a_d  = '0;
    a_ul = '0;
    a_ur = '0;
    a_l  = '0;
    a_r  = '0;
    a_dl = '0;
    a_dr = '0;
    if (interior) begin
      a_u  = idx_q - IW'(N);
      a_d  = idx_q + IW'(N);
      a_ul = a_u - IW'(1);
      a_ur = a_u + IW'(1);
      a_l  = idx_q - IW'(1);
      a_r  = idx_q + IW'(1);
      a_dl = a_d - IW'(1);
      a_dr = a_d + IW'(1);
    end
  end

  always_comb begin
    gx = (ext(pix_q[a_ur]) + (ext(pix_q[a_r]) <<< 1) + ext(pix_q[a_dr])) -
         (ext(pix_q[a_ul]) + (ext(pix_q[a_l]) <<< 1) + ext(pix_q[a_dl]));
    gy = (ext(pix_q[a_dl]) + (ext(pix_q[a_d]) <<< 1) + ext(pix_q[a_dr])) -
         (ext(pix_q[a_ul]) + (ext(pix_q[a_u]) <<< 1) + ext(pix_q[a_ur]));
    abs_gx = gx[SW-1] ? -gx : gx;
    abs_gy = gy[SW-1] ? -gy : gy;
    mag    = abs_gx + abs_gy;
    result = '0;
    if (interior) begin
      case (mode_q)
        2'd0:    result = sat(abs_gx);
        2'd1:    result = sat(abs_gy);
        2'd2:    result = sat(mag);
        default: result = (mag >= {4'b0000, thr_q}) ? '1 : '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    out_d   = out_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < NN; i++) begin
            pix_d[i] = input_matrix[i*DW +: DW];
            out_d[i] = '0;
          end
          mode_d  = mode;
          thr_d   = threshold;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        out_d[idx_q] = result;
        if (idx_q == IW'(NN - 1)) begin
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == CW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pix_q   <= '{default: '0};
      out_q   <= '{default: '0};
      mode_q  <= '0;
      thr_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    output_matrix = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      output_matrix[i*DW +: DW] = out_q[i];
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: doc/sobel_conv_engine.md
# sobel_conv_engine

Parametrised successor to the fixed 9x9 Sobel convolution block. It takes an N×N matrix of DW-bit pixels on a start pulse, sweeps a 3×3 Sobel window over it one pixel per clock, and produces an N×N output matrix. The output is selectable as |Gx|, |Gy|, |Gx|+|Gy| or a thresholded binary edge map. It sits in the convolution datapath in the same place as the fixed block and uses the same flattened-matrix start/done handshake.

## Interface
- N, default 9: matrix dimension, rows = cols = N; legal range N ≥ 3.
- DW, default 8: pixel width in bits for input and output.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- start  in  1  single-cycle request; sampled only while idle.
- mode  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=binary threshold; latched on start acceptance.
- threshold  in  DW  compare value for mode 3; latched on start acceptance.
- input_matrix  in  N*N*DW  pixel (r,c) at bits [(r*N+c)*DW +: DW]; latched on start acceptance.
- output_matrix  out  N*N*DW  same packing as input_matrix.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the frame is complete.

## Operation
- States:
  - IDLE: start=1 latches input_matrix, mode and threshold, clears output_matrix to 0, sets idx=0, goes to RUN.
  - RUN: computes pixel idx, writes it, increments idx. When idx = N*N-1 is written, goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Input capture: all operands are taken from the latched copy. Changing the inputs during RUN has no effect.
- Scan order: raster order, idx = r*N+c, r and c derived by counters (no divide).
- Border pixels (r=0, r=N-1, c=0, c=N-1): output 0.
- Interior pixel, with p(r,c) as the unsigned latched pixel:
  - Gx = [p(r-1,c+1) + 2p(r,c+1) + p(r+1,c+1)] − [p(r-1,c-1) + 2p(r,c-1) + p(r+1,c-1)]
  - Gy = [p(r+1,c-1) + 2p(r+1,c) + p(r+1,c+1)] − [p(r-1,c-1) + 2p(r-1,c) + p(r-1,c+1)]
- Arithmetic: signed, DW+4 bits internally, no overflow. |Gx|+|Gy| uses DW+4 bits.
- Modes 0–2: result saturates to 2^DW−1.
- Mode 3: output 2^DW−1 if the unsaturated |Gx|+|Gy| ≥ threshold, else 0.
- start while busy=1 or during DONE: ignored, with no effect on the current frame.
- Reset mid-frame: abandons the frame; state IDLE, all outputs at reset values.

## Timing
- Reset values: output_matrix=0, busy=0, done=0, state IDLE, idx=0.
- start sampled high at edge k (IDLE): busy=1 from edge k.
- Pixel idx is written at edge k+1+idx.
- Last pixel is written at edge k+N*N. busy falls and done rises at that same edge.
- done is high for exactly one cycle and clears at edge k+N*N+1, which returns to IDLE.
- A new start is accepted at edge k+N*N+1 or later.
- Total latency, start edge to done: N*N cycles (81 for N=9). Throughput is 1 pixel per clock.
- output_matrix fills progressively during RUN and holds stable from done until the next accepted start.

## Test plan
- Ramp test: N=9, DW=8, p(r,c)=9r+c.
  - mode 0: every interior pixel = 8.
  - mode 1: interior = 72.
  - mode 2: interior = 80.
  - All modes: all 32 border pixels = 0.
  - done appears exactly 81 cycles after the start edge.
- Threshold test: ramp input, mode 3.
  - threshold=80: interior = 255.
  - threshold=81: interior = 0.
  - Borders = 0 in both cases.
- Saturation test: columns 0–4 = 0, columns 5–8 = 255, mode 0.
  - Interior pixels at c=4 and c=5 = 255 (Gx = 1020, clamped); other interior pixels = 0.
  - mode 2 on the same input: same values.
- Busy guard: pulse start again at cycle 20 of a frame, with a different input_matrix and mode.
  - Frame result is unchanged.
  - Only one done pulse occurs.
  - busy stays high until edge k+81.
- Async reset: drive rst=0 mid-frame (cycle 40), between clock edges.
  - output_matrix=0, busy=0 and done=0 immediately, without waiting for a clock edge.
  - After rst=1, a new start completes normally with correct ramp results.
- Parameter sweep: N=3 and N=16 with DW=10 on the ramp input.
  - N=3: single interior pixel = 4·(2·1)=8 in mode 0.
  - N=16: interior |Gx| = 8 and |Gy| = 4·2·16 = 128.
  - Latency = N*N cycles in both cases.
